// File: rtl/tt_sweeper_if.sv
// Bundle of the sweep request, the FUT probe pair and the truth-table results.
// The tester side is master; the sweeper is slave.
interface tt_sweeper_if #(parameter int NIN = 7);
  localparam int W = 1 << NIN;

  logic           start;
  logic [W-1:0]   exp_tt;
  logic           f_in;
  logic [NIN-1:0] x;
  logic           busy;
  logic           done;
  logic [W-1:0]   tt;
  logic [NIN:0]   ones;
  logic           match;

  modport master (output start, exp_tt, f_in, input x, busy, done, tt, ones, match);
  modport slave  (input start, exp_tt, f_in, output x, busy, done, tt, ones, match);
endinterface

// File: rtl/tt_sweeper.sv
// Drives every input vector onto a function-under-test and assembles its
// truth table, minterm count and a compare against an expected table.
//
// state | meaning
// IDLE  | waiting for start; results and x hold
// SWEEP | x steps 0 .. 2^NIN-1, one vector per cycle
// DRAIN | x holds the last vector while LAT samples are still in flight
// DONE  | table complete; match and the done pulse are produced on its edge
module tt_sweeper #(
  parameter int NIN = 7,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_sweeper_if.slave  bus
);
  localparam int W  = 1 << NIN;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((LAT > 0) ? LAT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t         state, state_n;
  logic [NIN-1:0] x_q;
  logic [W-1:0]   tt_q;
  logic [W-1:0]   exp_q;
  logic [NIN:0]   ones_q;
  logic           done_q;
  logic           match_q;
  logic [DW-1:0]  drain_cnt;
  logic           last_vec;
  logic           samp_v;
  logic [NIN-1:0] samp_idx;

  assign last_vec = (x_q == {NIN{1'b1}});

  // Each vector index travels alongside the FUT pipeline so the sample lands
  // in the right table bit.
  generate
    if (LAT == 0) begin : g_comb
      assign samp_v   = (state == SWEEP);
      assign samp_idx = x_q;
    end else begin : g_pipe
      logic [LAT-1:0] pv;
      logic [NIN-1:0] pidx [LAT];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pv <= '0;
          for (int i = 0; i < LAT; i++) pidx[i] <= '0;
        end else begin
          pv[0]   <= (state == SWEEP);
          pidx[0] <= x_q;
          for (int i = 1; i < LAT; i++) begin
            pv[i]   <= pv[i-1];
            pidx[i] <= pidx[i-1];
          end
        end
      end

      assign samp_v   = pv[LAT-1];
      assign samp_idx = pidx[LAT-1];
    end
  endgenerate

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = SWEEP;
      SWEEP:   if (last_vec) state_n = (LAT > 0) ? DRAIN : DONE;
      DRAIN:   if (drain_cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_q       <= '0;
      tt_q      <= '0;
      exp_q     <= '0;
      ones_q    <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state  <= state_n;
      done_q <= (state == DONE);
      if (state == IDLE && bus.start) begin
        x_q     <= '0;
        tt_q    <= '0;
        ones_q  <= '0;
        match_q <= 1'b0;
        exp_q   <= bus.exp_tt;
      end else begin
        if (state == SWEEP && !last_vec) x_q <= x_q + 1'b1;
        if (state == SWEEP && last_vec) drain_cnt <= DRAIN_LOAD;
        else if (state == DRAIN) drain_cnt <= drain_cnt - 1'b1;
        if (samp_v) begin
          tt_q[samp_idx] <= bus.f_in;
          if (bus.f_in) ones_q <= ones_q + 1'b1;
        end
        if (state == DONE) match_q <= (tt_q == exp_q);
      end
    end
  end

  // done is registered from DONE, so it trails the final sample by one edge.
  assign bus.x     = x_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.tt    = tt_q;
  assign bus.ones  = ones_q;
  assign bus.match = match_q;
endmodule

// File: tb/tb_tt_sweeper.sv
// Bench for tt_sweeper: a combinational FUT on a LAT=0 instance and a
// two-flop FUT on a LAT=2 instance, driven from truth tables held here.
module tb_tt_sweeper;
  localparam int NIN = 7;
  localparam int W   = 128;
  localparam logic [W-1:0] K2 = 128'hfeeaeae8eaeaeac0fca8a8a8e8a8a880;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_sweeper_if #(.NIN(NIN)) ifa ();
  tt_sweeper_if #(.NIN(NIN)) ifb ();

  tt_sweeper #(.NIN(NIN), .LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  tt_sweeper #(.NIN(NIN), .LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int           cur = 0;
  logic         start_r = 1'b0;
  logic [W-1:0] exp_r = '0;
  logic [W-1:0] fut_a = '0;
  logic [W-1:0] fut_b = '0;
  logic         p1, p2;
  int           total = 0;
  int           bad = 0;

  assign ifa.start  = (cur == 0) && start_r;
  assign ifb.start  = (cur == 1) && start_r;
  assign ifa.exp_tt = exp_r;
  assign ifb.exp_tt = exp_r;
  assign ifa.f_in   = fut_a[ifa.x];
  always @(posedge clk) begin
    p1 <= fut_b[ifb.x];
    p2 <= p1;
  end
  assign ifb.f_in = p2;

  logic         o_busy, o_done, o_match;
  logic [6:0]   o_x;
  logic [W-1:0] o_tt;
  logic [7:0]   o_ones;
  always_comb begin
    o_busy  = (cur == 1) ? ifb.busy  : ifa.busy;
    o_done  = (cur == 1) ? ifb.done  : ifa.done;
    o_match = (cur == 1) ? ifb.match : ifa.match;
    o_x     = (cur == 1) ? ifb.x     : ifa.x;
    o_tt    = (cur == 1) ? ifb.tt    : ifa.tt;
    o_ones  = (cur == 1) ? ifb.ones  : ifa.ones;
  end

  typedef struct {
    int           sel;
    logic [W-1:0] fut;
    logic [W-1:0] expt;
    logic [W-1:0] want_tt;
    int           want_ones;
    logic         want_match;
  } vec_t;

  function automatic bit maj3(bit a, bit b, bit c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [W-1:0] tab_maj();
    logic [W-1:0] t;
    logic [6:0] v;
    for (int i = 0; i < W; i++) begin
      v = 7'(i);
      t[i] = maj3(v[0], v[1], v[2]);
    end
    return t;
  endfunction

  function automatic logic [W-1:0] tab_f2();
    logic [W-1:0] t;
    logic [6:0] v;
    for (int i = 0; i < W; i++) begin
      v = 7'(i);
      t[i] = maj3(maj3(v[0], v[3], v[4]), maj3(v[1], v[2], v[5]),
                  maj3(v[0], v[6], maj3(v[0], v[1], v[2])));
    end
    return t;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  // Waits for done after edge k; returns the number of edges past k.
  task automatic wait_done(input int pulse_at, output int n);
    n = 0;
    while (o_done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
      start_r = (n == pulse_at);
      if (n == 64) chk("x_mid", W'(o_x), W'(64));
      if (n == 100) chk("busy_mid", W'(o_busy), W'(1));
    end
  endtask

  task automatic sweep(input vec_t v, input int pulse_at, input bit hold);
    int lat, n;
    lat = (v.sel == 1) ? 2 : 0;
    cur = v.sel;
    if (v.sel == 1) fut_b = v.fut; else fut_a = v.fut;
    exp_r = v.expt;
    @(negedge clk); start_r = 1'b1;
    @(posedge clk); #1 start_r = 1'b0;
    chk("busy_start", W'(o_busy), W'(1));
    chk("x_start", W'(o_x), W'(0));
    wait_done(pulse_at, n);
    chk("done_latency", W'(n), W'(W + lat + 1));
    chk("tt", o_tt, v.want_tt);
    chk("ones", W'(o_ones), W'(v.want_ones));
    chk("match", W'(o_match), W'(v.want_match));
    chk("busy_done", W'(o_busy), W'(0));
    if (hold) start_r = 1'b1;
    @(posedge clk); #1;
    chk("done_single", W'(o_done), W'(0));
    chk("busy_after", W'(o_busy), W'(hold));
    start_r = 1'b0;
    if (hold) begin
      wait_done(-1, n);
      chk("b2b_latency", W'(n), W'(W + lat + 1));
      chk("b2b_tt", o_tt, v.want_tt);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    int  n;
    bit  seen;
    logic [W-1:0] t;

    vecs[0] = '{0, tab_maj(), {16{8'hE8}}, {16{8'hE8}}, 64, 1'b1};
    vecs[1] = '{0, tab_f2(), K2, K2, $countones(K2), 1'b1};
    vecs[2] = '{1, tab_f2(), K2, K2, $countones(K2), 1'b1};
    vecs[3] = '{1, tab_f2(), K2 ^ W'(1), K2, $countones(K2), 1'b0};
    vecs[4] = '{0, '0, '0, '0, 0, 1'b1};
    vecs[5] = '{1, '1, '1, '1, 128, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(ifa.busy), W'(0));
    chk("rst_done", W'(ifa.done), W'(0));
    chk("rst_x", W'(ifa.x), W'(0));
    chk("rst_tt", ifa.tt, W'(0));
    chk("rst_ones", W'(ifa.ones), W'(0));
    chk("rst_match", W'(ifa.match), W'(0));
    chk("rst_busy2", W'(ifb.busy), W'(0));
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) sweep(vecs[i], -1, 1'b0);

    // start pulsed at vector 40 must not disturb the sweep
    sweep(vecs[1], 40, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("no_restart", W'(o_busy), W'(0));

    // start held through DONE into IDLE is accepted once
    sweep(vecs[0], -1, 1'b1);

    // reset at vector 50 aborts the sweep silently
    cur = 0;
    fut_a = tab_f2();
    exp_r = K2;
    @(negedge clk); start_r = 1'b1;
    @(posedge clk); #1 start_r = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_busy", W'(o_busy), W'(0));
    chk("abort_x", W'(o_x), W'(0));
    chk("abort_tt", o_tt, W'(0));
    chk("abort_done", W'(o_done), W'(0));
    seen = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", W'(seen), W'(0));
    sweep(vecs[1], -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      rv.sel  = int'($urandom_range(0, 1));
      rv.fut  = t;
      rv.expt = ($urandom_range(0, 1) == 1) ? t : (t ^ (W'(1) << $urandom_range(0, W - 1)));
      rv.want_tt    = t;
      rv.want_ones  = $countones(t);
      rv.want_match = (rv.expt == t);
      sweep(rv, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
